ads8684_ctrl: RTL and testbench
===============================

Name: ads8684_ctrl

Overview:
- SPI master and channel scheduler for the ADS8684 4-channel ADC in the gradient controller.
- On a trigger it scans the enabled channels in ascending order, issuing one 32-bit manual-channel-select frame per channel, then one NO_OP frame to flush the pipelined last result.
- Results are returned as 16-bit words tagged with their channel, for downstream readback/monitor logic.

Parameters:
SCLK_DIV, 4, clk cycles per sclk half-period; legal range 1..255.
CSN_HIGH, 8, minimum clk cycles csn stays high between frames; legal range 1..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle scan trigger
auto  in  1  if high when a scan ends, the next scan starts immediately
ch_en  in  4  channel enable mask, bit n = channel n; sampled at scan start
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end
data_valid  out  1  one-cycle pulse; data/data_ch are valid
data_ch  out  2  channel of data
data  out  16  conversion result
csn  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, idle low
sdi  out  1  ADC serial data in
sdo  in  1  ADC serial data out

Behaviour:
- Reset, asynchronous: csn=1, sclk=0, sdi=0, busy=0, done=0, data_valid=0, data=0, data_ch=0, state IDLE. A mid-frame reset aborts the frame immediately and discards any pending result.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - On start=1 with ch_en!=0: latch ch_en, set busy=1 and go to SETUP on the next clk.
  - start with ch_en==0 is ignored.
  - start while busy=1 is ignored.
- Command word:
  - Channel frame: cmd = 16'hC000 | (ch<<10), i.e. C000, C400, C800, CC00.
  - Flush frame: cmd = 16'h0000.
  - Transmitted frame = {cmd, 16'h0000}, MSB first.
  - N enabled channels produce N+1 frames.
- SETUP: csn=0, sclk=0, sdi=frame[31], held for SCLK_DIV cycles.
- SHIFT, 32 bits; per bit:
  - sclk=1 for SCLK_DIV cycles; sdo is captured into the receive shift register on the clk edge that drives sclk 0->1.
  - Then sclk=0 for SCLK_DIV cycles; sdi updates to the next bit on the 1->0 transition.
  - sdi holds each bit through its entire high phase.
- HOLD: after the 32nd falling edge, sclk=0 and csn=0 for SCLK_DIV cycles, then csn=1.
- GAP: csn=1 and sdi=0 for CSN_HIGH cycles. At GAP entry:
  - If the frame is not the first of the scan, data = rx[31:16] and data_ch = channel of the previous frame's command.
  - data_valid pulses for exactly one cycle. data/data_ch hold until the next update.
- Frame timing: one frame = (66*SCLK_DIV + CSN_HIGH) clk cycles from csn fall to the next SETUP entry.
- End of GAP:
  - If frames remain, go to SETUP.
  - After the flush frame: pulse done for one cycle.
  - If auto=1 and the newly sampled ch_en!=0, stay busy and go to SETUP with the new mask; auto-restart skips IDLE.
  - Otherwise busy=0 in that same cycle and go to IDLE.
- rx[15:0] is ignored.
- Scheduling: ascending channel order within a scan, skipping disabled bits. The mask change takes effect only at scan boundaries.

Test Plan:
- SCLK_DIV=1, CSN_HIGH=2, ch_en=4'b0001, ADC model ain_0p=16'hCAFE; pulse start:
  - Two frames, sdi = C0000000 then 00000000.
  - One data_valid with data=CAFE, data_ch=0.
  - done pulses, then busy=0.
  - Each frame is 66+2 clk long.
- ch_en=4'b1111, ain_0..3 = 1111, 2222, 3333, 4444:
  - Five frames with commands C000, C400, C800, CC00, 0000.
  - Results in order (0,1111), (1,2222), (2,3333), (3,4444).
- ch_en=4'b1010, ain_1p=ABCD, ain_3p=1234:
  - Three frames C400, CC00, 0000.
  - Outputs (1,ABCD), (3,1234).
  - No data_valid for channels 0 or 2.
- start asserted again mid-scan, and start with ch_en=0 in IDLE:
  - Neither changes the frame sequence nor asserts busy.
- auto=1, ch_en=4'b0100:
  - After done, the next C800 frame starts after exactly CSN_HIGH gap cycles with busy continuously high.
  - Drop auto: the scan completes and busy falls.
- Assert rst during bit 10 of a frame:
  - Same cycle csn=1, sclk=0, sdi=0, busy=0.
  - No data_valid afterwards.
  - A new start gives a correct full scan.

Source files
------------

// File: rtl/ads8684_ctrl.sv
// ADS8684 SPI master and channel scheduler.
// Scans the enabled channels in ascending order with one manual-channel-select
// frame each, then one NO_OP frame to flush the pipelined last conversion.
module ads8684_ctrl #(
  parameter int SCLK_DIV = 4,
  parameter int CSN_HIGH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto,
  input  logic [3:0]  ch_en,
  output logic        busy,
  output logic        done,
  output logic        data_valid,
  output logic [1:0]  data_ch,
  output logic [15:0] data,
  output logic        csn,
  output logic        sclk,
  output logic        sdi,
  input  logic        sdo
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_M1 = 8'(SCLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(CSN_HIGH - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [5:0]  bit_cnt;
  logic [3:0]  pend;
  logic [1:0]  cur_ch, prev_ch;
  logic        cur_flush, first;
  logic [30:0] tx;
  logic [31:0] rx;

  logic        cnt_zero;
  logic        load_frame;
  logic        load_any;
  logic [3:0]  load_mask;
  logic [1:0]  load_ch;

  assign cnt_zero = (cnt == 8'd0);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: phase counters pace every state except IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && ch_en != 4'd0) state_nxt = SETUP;
      SETUP: if (cnt_zero) state_nxt = SHIFT;
      SHIFT: if (cnt_zero && !sclk && bit_cnt == 6'd32) state_nxt = HOLD;
      HOLD:  if (cnt_zero) state_nxt = GAP;
      GAP: begin
        if (cnt_zero) begin
          if (!cur_flush)                  state_nxt = SETUP;
          else if (auto && ch_en != 4'd0)  state_nxt = SETUP;
          else                             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the next frame: remaining mask mid-scan, fresh ch_en at a scan start.
  always_comb begin
    load_frame = (state_nxt == SETUP) && (state != SETUP);
    load_mask  = (state == GAP && !cur_flush) ? pend : ch_en;
    load_any   = (load_mask != 4'd0);
    load_ch    = 2'd0;
    if      (load_mask[0]) load_ch = 2'd0;
    else if (load_mask[1]) load_ch = 2'd1;
    else if (load_mask[2]) load_ch = 2'd2;
    else if (load_mask[3]) load_ch = 2'd3;
  end

  // Serial engine, scan bookkeeping and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn        <= 1'b1;
      sclk       <= 1'b0;
      sdi        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_valid <= 1'b0;
      data       <= 16'd0;
      data_ch    <= 2'd0;
      cnt        <= 8'd0;
      bit_cnt    <= 6'd0;
      pend       <= 4'd0;
      cur_ch     <= 2'd0;
      prev_ch    <= 2'd0;
      cur_flush  <= 1'b0;
      first      <= 1'b0;
      tx         <= 31'd0;
      rx         <= 32'd0;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;
      if (!cnt_zero) cnt <= cnt - 8'd1;

      case (state)
        IDLE: begin
          if (state_nxt == SETUP) begin
            busy  <= 1'b1;
            first <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            sclk    <= 1'b1;
            rx      <= {rx[30:0], sdo};
            cnt     <= DIV_M1;
            bit_cnt <= 6'd0;
          end
        end
        SHIFT: begin
          if (cnt_zero) begin
            cnt <= DIV_M1;
            if (sclk) begin
              sclk    <= 1'b0;
              sdi     <= tx[30];
              tx      <= {tx[29:0], 1'b0};
              bit_cnt <= bit_cnt + 6'd1;
            end else if (bit_cnt != 6'd32) begin
              sclk <= 1'b1;
              rx   <= {rx[30:0], sdo};
            end
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            csn     <= 1'b1;
            sdi     <= 1'b0;
            cnt     <= GAP_M1;
            first   <= 1'b0;
            prev_ch <= cur_ch;
            if (!first) begin
              data       <= rx[31:16];
              data_ch    <= prev_ch;
              data_valid <= 1'b1;
            end
          end
        end
        GAP: begin
          if (cnt_zero && cur_flush) begin
            done <= 1'b1;
            if (state_nxt == IDLE) busy <= 1'b0;
            else                   first <= 1'b1;
          end
        end
        default: ;
      endcase

      if (load_frame) begin
        csn       <= 1'b0;
        sclk      <= 1'b0;
        cnt       <= DIV_M1;
        cur_flush <= !load_any;
        cur_ch    <= load_ch;
        pend      <= load_mask & ~(4'b0001 << load_ch);
        sdi       <= load_any;
        tx        <= load_any ? {1'b1, 2'b00, load_ch, 26'd0} : 31'd0;
      end
    end
  end

endmodule

// File: tb/tb_ads8684_ctrl.sv
// Directed testbench for ads8684_ctrl with a behavioural ADS8684 model
// that answers each channel command one frame later.
module tb_ads8684_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        auto;
  logic [3:0]  ch_en;
  logic        busy, done, data_valid;
  logic [1:0]  data_ch;
  logic [15:0] data;
  logic        csn, sclk, sdi;
  logic        sdo = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ain [4];
  logic [31:0] frames [$];
  logic [31:0] dv [$];
  int          fall_t [$];
  int          rise_t [$];
  int          bits = 0;
  int          cyc = 0;

  ads8684_ctrl #(.SCLK_DIV(1), .CSN_HIGH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .auto(auto), .ch_en(ch_en),
    .busy(busy), .done(done), .data_valid(data_valid), .data_ch(data_ch),
    .data(data), .csn(csn), .sclk(sclk), .sdi(sdi), .sdo(sdo)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // ADC model and bus monitor, sampled on the falling clk edge.
  initial begin
    logic        csn_q, sclk_q;
    logic [31:0] cmd_sr, out_sr;
    logic [15:0] pending;
    csn_q = 1'b1; sclk_q = 1'b0; cmd_sr = '0; out_sr = '0; pending = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (csn_q && !csn) begin
        bits   = 0;
        out_sr = {pending, 16'h0000};
        sdo    = out_sr[31];
        fall_t.push_back(cyc);
      end
      if (!csn && sclk && !sclk_q) begin
        cmd_sr = {cmd_sr[30:0], sdi};
        bits++;
      end
      if (!csn && !sclk && sclk_q) begin
        out_sr = {out_sr[30:0], 1'b0};
        sdo    = out_sr[31];
      end
      if (!csn_q && csn) begin
        rise_t.push_back(cyc);
        if (bits == 32) begin
          frames.push_back(cmd_sr);
          if (cmd_sr[31:30] == 2'b11) pending = ain[cmd_sr[27:26]];
          else                        pending = 16'h0000;
        end
      end
      if (data_valid) dv.push_back({14'd0, data_ch, data});
      csn_q  = csn;
      sclk_q = sclk;
    end
  end

  function automatic logic [31:0] frame_at(input int i);
    if (i < frames.size()) return frames[i];
    return 'x;
  endfunction

  function automatic logic [31:0] dv_at(input int i);
    if (i < dv.size()) return dv[i];
    return 'x;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] mask);
    @(negedge clk);
    ch_en = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    check_output(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic clear_logs();
    frames.delete(); dv.delete(); fall_t.delete(); rise_t.delete();
  endtask

  initial begin
    logic [31:0] exp_f [5];
    logic [31:0] exp_d [4];
    int k, low;

    rst = 1'b1; start = 1'b0; auto = 1'b0; ch_en = 4'd0;
    for (int i = 0; i < 4; i++) ain[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check_output("rst csn",  {31'd0, csn}, 32'd1);
    check_output("rst sclk", {31'd0, sclk}, 32'd0);
    check_output("rst sdi",  {31'd0, sdi}, 32'd0);
    check_output("rst busy", {31'd0, busy}, 32'd0);
    check_output("rst done", {31'd0, done}, 32'd0);
    check_output("rst dv",   {31'd0, data_valid}, 32'd0);
    check_output("rst data", {14'd0, data_ch, data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single channel scan.
    $display("[TB] single channel scan");
    ain[0] = 16'hCAFE;
    clear_logs();
    apply_stimulus(4'b0001);
    check_output("t1 busy rises", {31'd0, busy}, 32'd1);
    wait_done(1000, "t1 done");
    check_output("t1 busy at done", {31'd0, busy}, 32'd0);
    check_output("t1 frames", frames.size(), 32'd2);
    check_output("t1 frame0", frame_at(0), 32'hC000_0000);
    check_output("t1 frame1", frame_at(1), 32'h0000_0000);
    check_output("t1 dv count", dv.size(), 32'd1);
    check_output("t1 dv0", dv_at(0), 32'h0000_CAFE);
    check_output("t1 frame len", (fall_t.size() > 1) ? fall_t[1] - fall_t[0] : -1, 32'd68);
    @(negedge clk);
    check_output("t1 data hold", {14'd0, data_ch, data}, 32'h0000_CAFE);

    // All four channels.
    $display("[TB] four channel scan");
    ain[0] = 16'h1111; ain[1] = 16'h2222; ain[2] = 16'h3333; ain[3] = 16'h4444;
    exp_f = '{32'hC000_0000, 32'hC400_0000, 32'hC800_0000, 32'hCC00_0000, 32'h0};
    exp_d = '{32'h0000_1111, 32'h0001_2222, 32'h0002_3333, 32'h0003_4444};
    clear_logs();
    apply_stimulus(4'b1111);
    wait_done(1000, "t2 done");
    check_output("t2 frames", frames.size(), 32'd5);
    for (int i = 0; i < 5; i++) check_output("t2 frame", frame_at(i), exp_f[i]);
    check_output("t2 dv count", dv.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_output("t2 dv", dv_at(i), exp_d[i]);

    // Sparse mask, plus restart attempt and mask change mid-scan.
    $display("[TB] sparse mask scan");
    ain[0] = 16'hFFFF; ain[1] = 16'hABCD; ain[2] = 16'hFFFF; ain[3] = 16'h1234;
    clear_logs();
    apply_stimulus(4'b1010);
    repeat (80) @(negedge clk);
    ch_en = 4'b0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1000, "t3 done");
    check_output("t3 frames", frames.size(), 32'd3);
    check_output("t3 frame0", frame_at(0), 32'hC400_0000);
    check_output("t3 frame1", frame_at(1), 32'hCC00_0000);
    check_output("t3 frame2", frame_at(2), 32'h0000_0000);
    check_output("t3 dv count", dv.size(), 32'd2);
    check_output("t3 dv0", dv_at(0), 32'h0001_ABCD);
    check_output("t3 dv1", dv_at(1), 32'h0003_1234);

    // Start with an empty mask in IDLE.
    clear_logs();
    apply_stimulus(4'b0000);
    repeat (20) @(negedge clk);
    check_output("t3 empty busy", {31'd0, busy}, 32'd0);
    check_output("t3 empty frames", fall_t.size(), 32'd0);

    // Auto restart keeps busy high with a CSN_HIGH gap.
    $display("[TB] auto restart");
    auto = 1'b1;
    ain[2] = 16'h7777;
    clear_logs();
    apply_stimulus(4'b0100);
    wait_done(1000, "t4 first done");
    check_output("t4 busy at done", {31'd0, busy}, 32'd1);
    auto = 1'b0;
    k = 0; low = 0;
    do begin
      @(negedge clk);
      k++;
      if (!busy && !done) low++;
    end while (!done && k < 1000);
    check_output("t4 second done", {31'd0, done}, 32'd1);
    check_output("t4 busy falls", {31'd0, busy}, 32'd0);
    check_output("t4 busy gaps", low, 32'd0);
    check_output("t4 frames", frames.size(), 32'd4);
    check_output("t4 frame2", frame_at(2), 32'hC800_0000);
    check_output("t4 restart gap", (fall_t.size() > 2 && rise_t.size() > 1) ? fall_t[2] - rise_t[1] : -1, 32'd2);
    check_output("t4 dv0", dv_at(0), 32'h0002_7777);
    check_output("t4 dv1", dv_at(1), 32'h0002_7777);

    // Reset during bit 10 of the second frame.
    $display("[TB] mid-frame reset");
    ain[0] = 16'h5A5A; ain[1] = 16'hA5A5;
    clear_logs();
    apply_stimulus(4'b0011);
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(frames.size() == 1 && bits >= 10) && k < 1000);
    check_output("t5 reached bit10", {31'd0, (frames.size() == 1 && bits >= 10)}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("t5 rst csn",  {31'd0, csn}, 32'd1);
    check_output("t5 rst sclk", {31'd0, sclk}, 32'd0);
    check_output("t5 rst sdi",  {31'd0, sdi}, 32'd0);
    check_output("t5 rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_output("t5 no dv", dv.size(), 32'd0);
    check_output("t5 idle", {31'd0, busy}, 32'd0);
    clear_logs();
    apply_stimulus(4'b0011);
    wait_done(1000, "t5 rescan done");
    check_output("t5 frames", frames.size(), 32'd3);
    check_output("t5 frame0", frame_at(0), 32'hC000_0000);
    check_output("t5 frame1", frame_at(1), 32'hC400_0000);
    check_output("t5 dv0", dv_at(0), 32'h0000_5A5A);
    check_output("t5 dv1", dv_at(1), 32'h0001_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
